// File: rtl/filter_tdm.sv
// Time-multiplexed pulse-response filter: walks a (value, timestamp) history
// through one external step-response lookup and one multiplier per evaluation.
module filter_tdm #(
    parameter int NUM_TAPS   = 8,
    parameter int IN_WIDTH   = 8,
    parameter int TIME_WIDTH = 32,
    parameter int DT_WIDTH   = 16,
    parameter int STEP_WIDTH = 18,
    parameter int STEP_LAT   = 2,
    parameter int OUT_WIDTH  = 16,
    parameter int OUT_SHIFT  = 0,
    parameter int SATURATE   = 1
) (
    input  logic                        clk_sys,
    input  logic                        rst,
    input  logic                        in_push,
    input  logic [IN_WIDTH-1:0]         in_value,
    input  logic [TIME_WIDTH-1:0]       time_now,
    input  logic                        eval_req,
    input  logic [TIME_WIDTH-1:0]       eval_time,
    output logic                        eval_busy,
    output logic                        step_req,
    output logic [$clog2(NUM_TAPS)-1:0] step_tap,
    output logic [DT_WIDTH-1:0]         step_dt,
    input  logic [STEP_WIDTH-1:0]       step_val,
    output logic [OUT_WIDTH-1:0]        out,
    output logic                        out_valid,
    output logic                        out_sat,
    output logic                        push_ovf
);

    localparam int TAP_W   = $clog2(NUM_TAPS);
    localparam int CNT_W   = TAP_W + 1;
    localparam int PULSE_W = STEP_WIDTH + 1;
    localparam int PROD_W  = PULSE_W + IN_WIDTH;
    localparam int ACC_W   = PROD_W + TAP_W;

    localparam logic signed [ACC_W-1:0] OUT_MAX =
        {{(ACC_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OUT_MIN =
        {{(ACC_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    state_t state, state_nxt;

    logic [IN_WIDTH-1:0]   hist_val  [NUM_TAPS];
    logic [TIME_WIDTH-1:0] hist_time [NUM_TAPS];
    logic [CNT_W-1:0]      hist_cnt;

    logic                  pend_valid;
    logic [IN_WIDTH-1:0]   pend_val;
    logic [TIME_WIDTH-1:0] pend_time;

    logic [TIME_WIDTH-1:0] eval_time_r;
    logic [TAP_W-1:0]      issue_k;

    logic                  rq_v   [STEP_LAT];
    logic [TAP_W-1:0]      rq_tap [STEP_LAT];
    logic                  arr_v;
    logic [TAP_W-1:0]      arr_tap;

    logic                        pa_v, pa_mask, pa_last;
    logic signed [PULSE_W-1:0]   pa_pulse;
    logic signed [IN_WIDTH-1:0]  pa_val;
    logic [STEP_WIDTH-1:0]       s_prev;
    logic signed [PULSE_W-1:0]   pulse_nxt;
    logic signed [PROD_W-1:0]    prod_full, prod;
    logic signed [ACC_W-1:0]     acc, acc_nxt, shifted;
    logic [OUT_WIDTH-1:0]        out_nxt;
    logic                        sat_nxt;

    logic                  hist_wr, pend_load, ovf_set;
    logic [IN_WIDTH-1:0]   wr_val;
    logic [TIME_WIDTH-1:0] wr_time;
    logic                  accept, last_issue;
    logic [TIME_WIDTH-1:0] dt_raw;
    logic                  dt_clamp;

    assign accept     = (state == IDLE) && eval_req;
    assign last_issue = (issue_k == TAP_W'(NUM_TAPS - 1));
    assign eval_busy  = (state == ISSUE) || (state == DRAIN);
    assign out_valid  = (state == DONE);

    // Lookup handshake: step_req is a one-cycle strobe with step_tap/step_dt
    // valid alongside it; the lookup has no back-pressure and must present
    // step_val exactly STEP_LAT cycles later.
    assign step_req = (state == ISSUE);
    assign step_tap = step_req ? issue_k : '0;
    assign dt_raw   = eval_time_r - hist_time[issue_k];
    assign dt_clamp = |(dt_raw >> DT_WIDTH);
    assign step_dt  = !step_req ? '0 : (dt_clamp ? '1 : dt_raw[DT_WIDTH-1:0]);

    assign arr_v   = rq_v[STEP_LAT-1];
    assign arr_tap = rq_tap[STEP_LAT-1];

    assign pulse_nxt = $signed({step_val[STEP_WIDTH-1], step_val})
                     - $signed({s_prev[STEP_WIDTH-1], s_prev});
    assign prod_full = pa_pulse * pa_val;
    assign prod      = pa_mask ? '0 : prod_full;
    assign acc_nxt   = acc + ACC_W'(prod);
    assign shifted   = acc_nxt >>> OUT_SHIFT;

    always_comb begin
        out_nxt = shifted[OUT_WIDTH-1:0];
        sat_nxt = 1'b0;
        if (SATURATE != 0) begin
            if (shifted > OUT_MAX) begin
                out_nxt = OUT_MAX[OUT_WIDTH-1:0];
                sat_nxt = 1'b1;
            end else if (shifted < OUT_MIN) begin
                out_nxt = OUT_MIN[OUT_WIDTH-1:0];
                sat_nxt = 1'b1;
            end
        end
    end

    // History is frozen while taps are in flight; the pending entry lands in DONE.
    always_comb begin
        hist_wr   = 1'b0;
        wr_val    = in_value;
        wr_time   = time_now;
        pend_load = 1'b0;
        ovf_set   = 1'b0;
        case (state)
            IDLE: hist_wr = in_push;
            ISSUE, DRAIN: begin
                if (in_push) begin
                    if (pend_valid) ovf_set = 1'b1;
                    else            pend_load = 1'b1;
                end
            end
            DONE: begin
                if (pend_valid) begin
                    hist_wr = 1'b1;
                    wr_val  = pend_val;
                    wr_time = pend_time;
                    ovf_set = in_push;
                end else begin
                    hist_wr = in_push;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (eval_req) state_nxt = ISSUE;
            ISSUE:   if (last_issue) state_nxt = DRAIN;
            DRAIN:   if (pa_v && pa_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (hist_wr) begin
            for (int i = NUM_TAPS - 1; i > 0; i--) begin
                hist_val[i]  <= hist_val[i-1];
                hist_time[i] <= hist_time[i-1];
            end
            hist_val[0]  <= wr_val;
            hist_time[0] <= wr_time;
        end
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            hist_cnt    <= '0;
            pend_valid  <= 1'b0;
            pend_val    <= '0;
            pend_time   <= '0;
            push_ovf    <= 1'b0;
            eval_time_r <= '0;
            issue_k     <= '0;
            for (int i = 0; i < STEP_LAT; i++) begin
                rq_v[i]   <= 1'b0;
                rq_tap[i] <= '0;
            end
            pa_v     <= 1'b0;
            pa_mask  <= 1'b0;
            pa_last  <= 1'b0;
            pa_pulse <= '0;
            pa_val   <= '0;
            s_prev   <= '0;
            acc      <= '0;
            out      <= '0;
            out_sat  <= 1'b0;
        end else begin
            state <= state_nxt;

            if (hist_wr && (hist_cnt != CNT_W'(NUM_TAPS)))
                hist_cnt <= hist_cnt + 1'b1;

            if (pend_load) begin
                pend_valid <= 1'b1;
                pend_val   <= in_value;
                pend_time  <= time_now;
            end else if (state == DONE) begin
                pend_valid <= 1'b0;
            end

            if (ovf_set)
                push_ovf <= 1'b1;

            if (accept) begin
                eval_time_r <= eval_time;
                issue_k     <= '0;
                acc         <= '0;
                s_prev      <= '0;
            end else if (step_req && !last_issue) begin
                issue_k <= issue_k + 1'b1;
            end

            rq_v[0]   <= step_req;
            rq_tap[0] <= issue_k;
            for (int i = 1; i < STEP_LAT; i++) begin
                rq_v[i]   <= rq_v[i-1];
                rq_tap[i] <= rq_tap[i-1];
            end

            // Stage A: difference of consecutive step samples gives the pulse.
            pa_v <= arr_v;
            if (arr_v) begin
                pa_pulse <= pulse_nxt;
                pa_val   <= hist_val[arr_tap];
                pa_mask  <= ({1'b0, arr_tap} >= hist_cnt);
                pa_last  <= (arr_tap == TAP_W'(NUM_TAPS - 1));
                s_prev   <= step_val;
            end

            // Stage B: multiply-accumulate; the last tap also produces the output.
            if (pa_v) begin
                acc <= acc_nxt;
                if (pa_last) begin
                    out     <= out_nxt;
                    out_sat <= sat_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_filter_tdm.sv
// Directed bench for filter_tdm: three instances (32-bit time / 16-bit out saturating,
// 16-bit time / 8-bit out saturating, 16-bit time / 8-bit out wrapping) share stimulus.
module tb_filter_tdm;

    logic        clk_sys = 1'b0;
    logic        rst = 1'b0;
    logic        in_push = 1'b0;
    logic [7:0]  in_value = '0;
    logic [31:0] time_now = '0;
    logic        eval_req = 1'b0;
    logic [31:0] eval_time = '0;

    logic        eval_busy_a, step_req_a, out_valid_a, out_sat_a, push_ovf_a;
    logic [1:0]  step_tap_a;
    logic [15:0] step_dt_a, out_a;
    logic [17:0] step_val_a;

    logic        eval_busy_b, step_req_b, out_valid_b, out_sat_b, push_ovf_b;
    logic [1:0]  step_tap_b;
    logic [15:0] step_dt_b;
    logic [7:0]  out_b;
    logic [17:0] step_val_b;

    logic        eval_busy_c, step_req_c, out_valid_c, out_sat_c, push_ovf_c;
    logic [1:0]  step_tap_c;
    logic [15:0] step_dt_c;
    logic [7:0]  out_c;
    logic [17:0] step_val_c;

    logic [16:0] exp_q_a[$];
    logic [8:0]  exp_q_b[$];
    logic [8:0]  exp_q_c[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int acc_cyc = 0;

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc <= cyc + 1;

    filter_tdm #(.NUM_TAPS(4), .IN_WIDTH(8), .TIME_WIDTH(32), .DT_WIDTH(16), .STEP_WIDTH(18),
                 .STEP_LAT(2), .OUT_WIDTH(16), .OUT_SHIFT(0), .SATURATE(1)) u_a (
        .clk_sys(clk_sys), .rst(rst), .in_push(in_push), .in_value(in_value),
        .time_now(time_now), .eval_req(eval_req), .eval_time(eval_time),
        .eval_busy(eval_busy_a), .step_req(step_req_a), .step_tap(step_tap_a),
        .step_dt(step_dt_a), .step_val(step_val_a), .out(out_a), .out_valid(out_valid_a),
        .out_sat(out_sat_a), .push_ovf(push_ovf_a));

    filter_tdm #(.NUM_TAPS(4), .IN_WIDTH(8), .TIME_WIDTH(16), .DT_WIDTH(16), .STEP_WIDTH(18),
                 .STEP_LAT(2), .OUT_WIDTH(8), .OUT_SHIFT(0), .SATURATE(1)) u_b (
        .clk_sys(clk_sys), .rst(rst), .in_push(in_push), .in_value(in_value),
        .time_now(time_now[15:0]), .eval_req(eval_req), .eval_time(eval_time[15:0]),
        .eval_busy(eval_busy_b), .step_req(step_req_b), .step_tap(step_tap_b),
        .step_dt(step_dt_b), .step_val(step_val_b), .out(out_b), .out_valid(out_valid_b),
        .out_sat(out_sat_b), .push_ovf(push_ovf_b));

    filter_tdm #(.NUM_TAPS(4), .IN_WIDTH(8), .TIME_WIDTH(16), .DT_WIDTH(16), .STEP_WIDTH(18),
                 .STEP_LAT(2), .OUT_WIDTH(8), .OUT_SHIFT(0), .SATURATE(0)) u_c (
        .clk_sys(clk_sys), .rst(rst), .in_push(in_push), .in_value(in_value),
        .time_now(time_now[15:0]), .eval_req(eval_req), .eval_time(eval_time[15:0]),
        .eval_busy(eval_busy_c), .step_req(step_req_c), .step_tap(step_tap_c),
        .step_dt(step_dt_c), .step_val(step_val_c), .out(out_c), .out_valid(out_valid_c),
        .out_sat(out_sat_c), .push_ovf(push_ovf_c));

    // Step-response lookup model: s = min(dt, 100), returned two cycles after the request.
    function automatic logic [17:0] step_fn(input logic [15:0] dt);
        return (dt >= 16'd100) ? 18'd100 : {2'b00, dt};
    endfunction

    logic [15:0] da1, da2, db1, db2, dc1, dc2;
    always @(posedge clk_sys) begin
        da1 <= step_dt_a; da2 <= da1;
        db1 <= step_dt_b; db2 <= db1;
        dc1 <= step_dt_c; dc2 <= dc1;
    end
    assign step_val_a = step_fn(da2);
    assign step_val_b = step_fn(db2);
    assign step_val_c = step_fn(dc2);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every out_valid must match the oldest queued expectation.
    always @(negedge clk_sys) begin
        logic [16:0] ea;
        logic [8:0]  eb, ec;
        if (out_valid_a) begin
            chk("a_out_valid_expected", 32'(exp_q_a.size() > 0), 32'd1);
            if (exp_q_a.size() > 0) begin
                ea = exp_q_a.pop_front();
                chk("a_out_sat", {15'b0, out_sat_a, out_a}, {15'b0, ea});
            end
        end
        if (out_valid_b) begin
            chk("b_out_valid_expected", 32'(exp_q_b.size() > 0), 32'd1);
            if (exp_q_b.size() > 0) begin
                eb = exp_q_b.pop_front();
                chk("b_out_sat", {23'b0, out_sat_b, out_b}, {23'b0, eb});
            end
        end
        if (out_valid_c) begin
            chk("c_out_valid_expected", 32'(exp_q_c.size() > 0), 32'd1);
            if (exp_q_c.size() > 0) begin
                ec = exp_q_c.pop_front();
                chk("c_out_sat", {23'b0, out_sat_c, out_c}, {23'b0, ec});
            end
        end
    end

    task automatic do_reset();
        in_push  = 1'b0;
        eval_req = 1'b0;
        rst      = 1'b1;
        @(negedge clk_sys);
        rst      = 1'b0;
        @(negedge clk_sys);
    endtask

    task automatic push(input int v, input logic [31:0] t);
        in_push  = 1'b1;
        in_value = 8'(v);
        time_now = t;
        @(negedge clk_sys);
        in_push  = 1'b0;
    endtask

    // Returns in cycle 1 of the evaluation; b2b holds eval_req through a DONE cycle first.
    task automatic issue_eval(input logic [31:0] t, input int ea, input bit sa, input int eb,
                              input bit sb, input int ec, input bit chk_dt,
                              input logic [15:0] dt0_a, input logic [15:0] dt0_b, input bit b2b);
        exp_q_a.push_back({sa, 16'(ea)});
        exp_q_b.push_back({sb, 8'(eb)});
        exp_q_c.push_back({1'b0, 8'(ec)});
        eval_req  = 1'b1;
        eval_time = t;
        if (b2b) @(negedge clk_sys);
        acc_cyc = cyc;
        @(negedge clk_sys);
        eval_req = 1'b0;
        if (chk_dt) begin
            chk("tap0_step_req", 32'(step_req_a), 32'd1);
            chk("tap0_step_tap", 32'(step_tap_a), 32'd0);
            chk("tap0_step_dt_a", 32'(step_dt_a), 32'(dt0_a));
            chk("tap0_step_dt_b", 32'(step_dt_b), 32'(dt0_b));
        end
    endtask

    task automatic wait_out();
        while (!out_valid_a && (cyc - acc_cyc) < 30) @(negedge clk_sys);
        chk("out_valid_latency", 32'(cyc - acc_cyc), 32'd8);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk_sys);
        do_reset();
        chk("rst_out", 32'(out_a), 32'd0);
        chk("rst_out_valid", 32'(out_valid_a), 32'd0);
        chk("rst_eval_busy", 32'(eval_busy_a), 32'd0);
        chk("rst_step_req", 32'(step_req_a), 32'd0);
        chk("rst_step_dt", 32'(step_dt_a), 32'd0);
        chk("rst_out_sat", 32'(out_sat_a), 32'd0);
        chk("rst_push_ovf", 32'(push_ovf_a), 32'd0);

        // Single entry, three taps masked.
        push(2, 10);
        issue_eval(30, 40, 0, 40, 0, 40, 1, 20, 20, 0);
        chk("busy_cycle1", 32'(eval_busy_a), 32'd1);
        wait_out();

        // Two entries: -1*20 + 2*(60-20) = 60.
        do_reset();
        push(2, 10);
        push(-1, 50);
        issue_eval(70, 60, 0, 60, 0, 60, 1, 20, 20, 0);
        wait_out();

        // Five pushes: oldest dropped, 5*20+4*10-2*10+1*10 = 130.
        do_reset();
        push(3, 0); push(1, 10); push(-2, 20); push(4, 30); push(5, 40);
        issue_eval(60, 130, 0, 127, 1, 'h82, 1, 20, 20, 0);
        wait_out();

        // Stale contents after reset must be masked: 7*10 = 70.
        do_reset();
        push(7, 50);
        issue_eval(60, 70, 0, 70, 0, 70, 1, 10, 10, 0);
        wait_out();

        // Time wrap: 16-bit instances see dt=20, 32-bit instance clamps.
        do_reset();
        push(2, 65530);
        issue_eval(14, 200, 0, 40, 0, 40, 1, 16'hFFFF, 16'd20, 0);
        wait_out();

        // Eval earlier than the entry.
        do_reset();
        push(2, 10);
        issue_eval(5, 200, 0, 127, 1, 'hC8, 1, 16'hFFFF, 16'hFFFB, 0);
        wait_out();

        // 10000 and -12800: saturate vs wrap on the 8-bit outputs.
        do_reset();
        push(100, 0);
        issue_eval(100, 10000, 0, 127, 1, 'h10, 1, 100, 100, 0);
        wait_out();
        do_reset();
        push(-128, 0);
        issue_eval(100, -12800, 0, -128, 1, 0, 1, 100, 100, 0);
        wait_out();

        // Pushes and eval_req while busy, then a back-to-back request through DONE.
        do_reset();
        push(1, 0);
        issue_eval(100, 100, 0, 100, 0, 100, 1, 100, 100, 0);
        push(50, 90);
        push(60, 95);
        eval_req  = 1'b1;
        eval_time = 0;
        @(negedge clk_sys);
        eval_req = 1'b0;
        chk("busy_mid_eval", 32'(eval_busy_a), 32'd1);
        wait_out();
        chk("busy_in_done", 32'(eval_busy_a), 32'd0);
        chk("push_ovf_a", 32'(push_ovf_a), 32'd1);
        chk("push_ovf_b", 32'(push_ovf_b), 32'd1);
        chk("push_ovf_c", 32'(push_ovf_c), 32'd1);
        issue_eval(100, 590, 0, 127, 1, 'h4E, 1, 10, 10, 1);
        wait_out();

        // Reset at cycle 3 of an evaluation aborts it.
        @(negedge clk_sys);
        eval_req  = 1'b1;
        eval_time = 200;
        @(negedge clk_sys);
        eval_req = 1'b0;
        @(negedge clk_sys);
        @(negedge clk_sys);
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(eval_busy_a), 32'd0);
        chk("abort_out_a", 32'(out_a), 32'd0);
        chk("abort_out_b", 32'(out_b), 32'd0);
        chk("abort_out_sat_b", 32'(out_sat_b), 32'd0);
        chk("abort_push_ovf", 32'(push_ovf_a), 32'd0);
        @(negedge clk_sys);
        rst = 1'b0;
        repeat (12) @(negedge clk_sys);
        chk("abort_idle_busy", 32'(eval_busy_a), 32'd0);

        // Empty history evaluates to zero.
        issue_eval(200, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        wait_out();

        repeat (3) @(negedge clk_sys);
        chk("queues_drained", 32'(exp_q_a.size() + exp_q_b.size() + exp_q_c.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
